// File: rtl/hist_calc_if.sv
// Bus bundle for hist_calc: start/busy/done control, ram_in read port, bin readout.
// HIST_PEAK_EN adds the peak_bin/peak_cnt outputs.
interface hist_calc_if #(
    parameter int TOTAL_PIXEL_BIT = 4,
    parameter int CNT_BIT         = 4
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic [TOTAL_PIXEL_BIT-1:0] rd_addr;
    logic [7:0]                 rd_data;
    logic [7:0]                 bin_addr;
    logic [CNT_BIT-1:0]         bin_data;
`ifdef HIST_PEAK_EN
    logic [7:0]                 peak_bin;
    logic [CNT_BIT-1:0]         peak_cnt;
`endif

    modport master (
        input  start, rd_data, bin_addr,
        output busy, done, rd_addr, bin_data
`ifdef HIST_PEAK_EN
        , output peak_bin, peak_cnt
`endif
    );

    modport slave (
        output start, rd_data, bin_addr,
        input  busy, done, rd_addr, bin_data
`ifdef HIST_PEAK_EN
        , input peak_bin, peak_cnt
`endif
    );
endinterface

// File: rtl/hist_calc.sv
// 256-bin intensity histogram over one ram_in frame per start; registered bin readout.
// Optional HIST_PEAK_EN tracks the first bin to reach the highest count.
module hist_calc #(
    parameter int W               = 2,
    parameter int H               = 5,
    parameter int TOTAL_PIXEL     = W*H,
    parameter int TOTAL_PIXEL_BIT = $clog2(W*H),
    parameter int CNT_BIT         = $clog2(W*H+1)
) (
    input  logic        clk,
    input  logic        rst_n,
    hist_calc_if.master bus
);
    localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL-1);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, LAST, DONE} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 clr_idx;
    logic [TOTAL_PIXEL_BIT-1:0] rd_addr_q;
    logic                       pix_vld;
    logic [CNT_BIT-1:0]         bin_mem [256];
    logic [CNT_BIT-1:0]         acc_cnt;
    logic                       accept;

    assign accept   = (state_q == IDLE) && bus.start;
    assign acc_cnt  = bin_mem[bus.rd_data] + CNT_BIT'(1);
    assign bus.busy = (state_q == CLEAR) || (state_q == SCAN) || (state_q == LAST);
    assign bus.done = (state_q == DONE);
    assign bus.rd_addr = rd_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   if (clr_idx == 8'hFF) state_d = SCAN;
            SCAN:    if (rd_addr_q == LAST_ADDR) state_d = LAST;
            LAST:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pix_vld flags the cycle in which rd_data returns the address issued one cycle earlier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_idx   <= '0;
            rd_addr_q <= '0;
            pix_vld   <= 1'b0;
        end else begin
            pix_vld <= (state_q == SCAN);
            if (accept)                  clr_idx <= '0;
            else if (state_q == CLEAR)   clr_idx <= clr_idx + 8'd1;
            if (state_q == CLEAR && clr_idx == 8'hFF)
                rd_addr_q <= '0;
            else if (state_q == SCAN && rd_addr_q != LAST_ADDR)
                rd_addr_q <= rd_addr_q + TOTAL_PIXEL_BIT'(1);
        end
    end

    // Bin memory is deliberately unreset; CLEAR initialises it on every run
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            bin_mem[clr_idx] <= '0;
        else if (pix_vld)
            bin_mem[bus.rd_data] <= acc_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.bin_data <= '0;
        else        bus.bin_data <= bin_mem[bus.bin_addr];
    end

`ifdef HIST_PEAK_EN
    // Strict compare: a later bin only wins by exceeding, so ties keep the earlier bin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.peak_bin <= '0;
            bus.peak_cnt <= '0;
        end else if (accept) begin
            bus.peak_bin <= '0;
            bus.peak_cnt <= '0;
        end else if (pix_vld && acc_cnt > bus.peak_cnt) begin
            bus.peak_bin <= bus.rd_data;
            bus.peak_cnt <= acc_cnt;
        end
    end
`endif
endmodule
